zb_tx_frame_sequencer: RTL and testbench
========================================

Name: zb_tx_frame_sequencer

Overview:
Sequences the O-QPSK coder for one IEEE 802.15.4 PHY frame.
- Emits the synchronisation header (preamble, SFD), then the PHR length field, then the CPU-written payload symbols pulled from an internal symbol FIFO.
- Sits between the CPU write interface and the coder symbol input.
- Owns frame timing, FIFO buffering and error reporting.

Parameters:
DATA_WIDTH, 4, symbol width in bits (one 802.15.4 symbol).
ADDR_WIDTH, 2, FIFO address width; depth = 2**ADDR_WIDTH = 4.
PREAMBLE_SYMS, 8, number of zero symbols in the preamble.
LEN_WIDTH, 7, PHR frame-length width in bytes (max 127).

Ports:
inClock  in  1  system clock; all logic on rising edge.
inReset  in  1  synchronous reset, active-high.
inWriteEnable  in  1  push inCPUdata into the symbol FIFO.
inCPUdata  in  DATA_WIDTH  payload symbol from the CPU.
inStartTx  in  1  start-frame request, single-cycle pulse.
inFrameLen  in  LEN_WIDTH  payload length in bytes; sampled with inStartTx.
inSymReady  in  1  coder can accept a symbol this cycle.
o_symValid  out  1  o_symData holds a valid symbol.
o_symData  out  DATA_WIDTH  symbol to the coder.
o_busy  out  1  frame in progress.
o_txDone  out  1  one-cycle pulse after the last payload symbol transfers.
o_fifoFull  out  1  symbol FIFO full.
o_error  out  1  sticky error flag (overflow, underrun, bad length).

Behaviour:
- Reset (inReset=1 on an edge): FSM to IDLE, FIFO flushed, all outputs 0. Reset applies mid-frame as well; no partial symbol is emitted afterwards.
- Transfer rule: a symbol transfers when o_symValid && inSymReady. While o_symValid=1 && inSymReady=0, o_symData is held stable.
- FSM states: IDLE, PREAMBLE, SFD, PHR, PAYLOAD, DONE.
  - IDLE: o_busy=0, o_symValid=0. On inStartTx with inFrameLen!=0: latch the length, clear o_error, go to PREAMBLE. o_busy=1 and o_symValid=1 on the next cycle.
  - PREAMBLE: symbol 0x0, PREAMBLE_SYMS transfers.
  - SFD: 0xA7 sent low nibble first, so symbols 0x7 then 0xA.
  - PHR: {1'b0, len} sent low nibble first, then high nibble.
  - PAYLOAD: 2*len symbols in FIFO order. o_symValid = !fifo_empty; o_symData = FIFO head; pop on transfer.
  - After the last payload transfer go to DONE. DONE lasts one cycle: o_txDone=1, o_symValid=0, o_busy=0. Then IDLE.
- Total transfers per frame = PREAMBLE_SYMS + 4 + 2*len.
- Bad length: inStartTx with inFrameLen==0 sets o_error=1 and stays in IDLE.
- inStartTx while o_busy=1 is ignored, with no error.
- Underrun: in PAYLOAD, if inSymReady=1 and the FIFO is empty, then:
  - set o_error=1, flush the FIFO, go to IDLE next cycle;
  - no o_txDone pulse.
- Overflow: inWriteEnable while o_fifoFull=1 with no pop in the same cycle drops the symbol and sets o_error=1.
  - Push and pop in the same cycle on a full FIFO: both happen and the FIFO stays full, no error.
- Writes are accepted in any state, including IDLE (pre-loading) and during PREAMBLE/SFD/PHR.
- FIFO pointers wrap modulo depth. Occupancy counter is ADDR_WIDTH+1 bits wide. o_fifoFull = (count == depth).
- Payload symbol counter is LEN_WIDTH+1 bits wide; no wrap is possible at len=127.
- o_error is cleared only by reset or by an accepted inStartTx.
- All outputs are registered except o_symValid/o_symData, which are driven from the FSM and FIFO head registers with no combinational path from inSymReady.

Decomposition:
- Package zb_tx_pkg contains:
  - state enum tx_state_t {IDLE, PREAMBLE, SFD, PHR, PAYLOAD, DONE};
  - localparam SFD_BYTE = 8'hA7;
  - localparam PREAMBLE_SYM = 4'h0.
- One sub-module, zb_sym_fifo: synchronous FIFO, DATA_WIDTH x 2**ADDR_WIDTH, with push/pop/full/empty/flush, first-word-fall-through head output.

Test Plan:
1. Reset held 5 cycles, then released -> o_symValid, o_busy, o_txDone, o_fifoFull, o_error all 0; the first start works normally.
2. Write 0xB, 0xF; inStartTx with len=1; inSymReady=1 constantly -> symbol stream 0,0,0,0,0,0,0,0,7,A,1,0,B,F (14 transfers), then o_txDone high for exactly 1 cycle, then o_busy=0.
3. Same frame as test 2 with inSymReady toggling 1/0 every cycle -> identical 14-symbol sequence; o_symData stable on every cycle where valid=1 and ready=0.
4. Write 0xE, 0x5; start with len=2 -> after 0x5 transfers, the next ready cycle gives o_error=1 and o_busy=0 next cycle; no o_txDone.
5. Five writes in IDLE (B, F, E, 5, A) -> o_fifoFull=1 after the 4th write; 0xA is dropped with o_error=1; then start with len=2 transmits B,F,E,5 and clears o_error.
6. Start with len=0 -> o_error=1, o_busy stays 0. Separately, assert reset during PAYLOAD -> next cycle all outputs 0 and FIFO empty (o_fifoFull=0).

Source files
------------

// File: rtl/zb_tx_pkg.sv
// Shared types and constants for the 802.15.4 O-QPSK transmit frame sequencer.
package zb_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    SFD,
    PHR,
    PAYLOAD,
    DONE
  } tx_state_t;

  localparam logic [7:0] SFD_BYTE     = 8'hA7;
  localparam logic [3:0] PREAMBLE_SYM = 4'h0;

endpackage

// File: rtl/zb_sym_fifo.sv
// Synchronous symbol FIFO with first-word-fall-through head and registered full/empty flags.
module zb_sym_fifo #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] head,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_DEPTH = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [ADDR_WIDTH:0]   count, count_nxt;
  logic                  push_ok, pop_ok;

  // A push into a full FIFO is still legal when the head leaves in the same cycle.
  assign pop_ok   = pop && !empty;
  assign push_ok  = push && (!full || pop_ok);
  assign overflow = push && full && !pop_ok;
  assign head     = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    case ({push_ok, pop_ok})
      2'b10:   count_nxt = count + CNT_ONE;
      2'b01:   count_nxt = count - CNT_ONE;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
      count <= count_nxt;
      full  <= (count_nxt == CNT_DEPTH);
      empty <= (count_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/zb_tx_frame_sequencer.sv
// Frame sequencer feeding the O-QPSK coder: preamble, SFD, PHR, then FIFO payload symbols.
//
// state    | meaning
// IDLE     | waiting for a start request; writes may pre-load the FIFO
// PREAMBLE | sending PREAMBLE_SYMS zero symbols
// SFD      | sending 0xA7, low nibble first
// PHR      | sending {0,len}, low nibble first
// PAYLOAD  | sending 2*len symbols from the FIFO
// DONE     | one-cycle completion pulse
module zb_tx_frame_sequencer
  import zb_tx_pkg::*;
#(
  parameter int DATA_WIDTH    = 4,
  parameter int ADDR_WIDTH    = 2,
  parameter int PREAMBLE_SYMS = 8,
  parameter int LEN_WIDTH     = 7
) (
  input  logic                  inClock,
  input  logic                  inReset,
  input  logic                  inWriteEnable,
  input  logic [DATA_WIDTH-1:0] inCPUdata,
  input  logic                  inStartTx,
  input  logic [LEN_WIDTH-1:0]  inFrameLen,
  input  logic                  inSymReady,
  output logic                  o_symValid,
  output logic [DATA_WIDTH-1:0] o_symData,
  output logic                  o_busy,
  output logic                  o_txDone,
  output logic                  o_fifoFull,
  output logic                  o_error
);

  localparam int CNT_W = LEN_WIDTH + 1;
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] PREAMBLE_TOP = CNT_W'(PREAMBLE_SYMS - 1);

  tx_state_t             state, state_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic [LEN_WIDTH-1:0]  len_q, len_nxt;
  logic                  error_nxt;
  logic                  fifo_flush, fifo_pop;
  logic                  fifo_full, fifo_empty, fifo_overflow;
  logic [DATA_WIDTH-1:0] fifo_head;
  logic [LEN_WIDTH:0]    phr_byte;
  logic                  xfer;

  assign phr_byte   = {1'b0, len_q};
  assign xfer       = o_symValid && inSymReady;
  assign o_fifoFull = fifo_full;

  zb_sym_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_fifo (
    .clk      (inClock),
    .rst      (inReset),
    .flush    (fifo_flush),
    .push     (inWriteEnable),
    .pop      (fifo_pop),
    .wdata    (inCPUdata),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .overflow (fifo_overflow)
  );

  always_ff @(posedge inClock) begin
    if (inReset) begin
      state    <= IDLE;
      cnt      <= '0;
      len_q    <= '0;
      o_error  <= 1'b0;
      o_busy   <= 1'b0;
      o_txDone <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      len_q    <= len_nxt;
      o_error  <= error_nxt;
      o_busy   <= (state_nxt == PREAMBLE) || (state_nxt == SFD) ||
                  (state_nxt == PHR) || (state_nxt == PAYLOAD);
      o_txDone <= (state_nxt == DONE);
    end
  end

  // cnt is a down-counter reused per phase; in SFD/PHR cnt[0]=1 selects the low nibble.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    len_nxt    = len_q;
    error_nxt  = o_error;
    fifo_flush = 1'b0;
    fifo_pop   = 1'b0;
    o_symValid = 1'b0;
    o_symData  = '0;

    case (state)
      IDLE: begin
        if (inStartTx) begin
          if (inFrameLen != '0) begin
            len_nxt   = inFrameLen;
            error_nxt = 1'b0;
            cnt_nxt   = PREAMBLE_TOP;
            state_nxt = PREAMBLE;
          end else begin
            error_nxt = 1'b1;
          end
        end
      end
      PREAMBLE: begin
        o_symValid = 1'b1;
        o_symData  = DATA_WIDTH'(PREAMBLE_SYM);
        if (xfer) begin
          if (cnt == '0) begin
            cnt_nxt   = CNT_ONE;
            state_nxt = SFD;
          end else begin
            cnt_nxt = cnt - CNT_ONE;
          end
        end
      end
      SFD: begin
        o_symValid = 1'b1;
        o_symData  = cnt[0] ? SFD_BYTE[DATA_WIDTH-1:0] : SFD_BYTE[2*DATA_WIDTH-1:DATA_WIDTH];
        if (xfer) begin
          if (cnt == '0) begin
            cnt_nxt   = CNT_ONE;
            state_nxt = PHR;
          end else begin
            cnt_nxt = cnt - CNT_ONE;
          end
        end
      end
      PHR: begin
        o_symValid = 1'b1;
        o_symData  = cnt[0] ? phr_byte[DATA_WIDTH-1:0] : phr_byte[2*DATA_WIDTH-1:DATA_WIDTH];
        if (xfer) begin
          if (cnt == '0) begin
            cnt_nxt   = {len_q, 1'b0} - CNT_ONE;
            state_nxt = PAYLOAD;
          end else begin
            cnt_nxt = cnt - CNT_ONE;
          end
        end
      end
      PAYLOAD: begin
        o_symValid = !fifo_empty;
        o_symData  = fifo_head;
        if (xfer) begin
          fifo_pop = 1'b1;
          if (cnt == '0) begin
            state_nxt = DONE;
          end else begin
            cnt_nxt = cnt - CNT_ONE;
          end
        end else if (inSymReady) begin
          // Coder wants a symbol the CPU never supplied: abandon the frame.
          error_nxt  = 1'b1;
          fifo_flush = 1'b1;
          state_nxt  = IDLE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    if (fifo_overflow) error_nxt = 1'b1;
  end

endmodule

// File: tb/tb_zb_tx_frame_sequencer.sv
// Directed bench for zb_tx_frame_sequencer: frame streams, back-pressure, underrun, overflow, reset.
module tb_zb_tx_frame_sequencer;

  logic       inClock = 1'b0;
  logic       inReset = 1'b1;
  logic       inWriteEnable = 1'b0;
  logic [3:0] inCPUdata = 4'h0;
  logic       inStartTx = 1'b0;
  logic [6:0] inFrameLen = 7'd0;
  logic       inSymReady = 1'b0;
  logic       o_symValid;
  logic [3:0] o_symData;
  logic       o_busy;
  logic       o_txDone;
  logic       o_fifoFull;
  logic       o_error;

  int errors = 0;
  int checks = 0;

  logic [3:0] cap[$];
  logic [3:0] exp_q[$];
  int         done_cnt;
  int         hold_bad;
  bit         timed_out;
  logic       err_after_start;

  zb_tx_frame_sequencer dut (
    .inClock       (inClock),
    .inReset       (inReset),
    .inWriteEnable (inWriteEnable),
    .inCPUdata     (inCPUdata),
    .inStartTx     (inStartTx),
    .inFrameLen    (inFrameLen),
    .inSymReady    (inSymReady),
    .o_symValid    (o_symValid),
    .o_symData     (o_symData),
    .o_busy        (o_busy),
    .o_txDone      (o_txDone),
    .o_fifoFull    (o_fifoFull),
    .o_error       (o_error)
  );

  always #5 inClock = ~inClock;

  task automatic tick();
    @(posedge inClock);
    #1;
  endtask

  task automatic write_sym(input logic [3:0] d);
    inWriteEnable = 1'b1;
    inCPUdata     = d;
    tick();
    inWriteEnable = 1'b0;
  endtask

  task automatic expect_header(input logic [6:0] len);
    exp_q.delete();
    repeat (8) exp_q.push_back(4'h0);
    exp_q.push_back(4'h7);
    exp_q.push_back(4'hA);
    exp_q.push_back(len[3:0]);
    exp_q.push_back({1'b0, len[6:4]});
  endtask

  function automatic int stream_diff();
    if (cap.size() != exp_q.size()) return -2;
    foreach (cap[i]) if (cap[i] !== exp_q[i]) return i;
    return -1;
  endfunction

  // Starts a frame and records every transfer until the sequencer is idle again.
  task automatic run_frame(input logic [6:0] len, input bit toggle, input bit poke);
    logic [3:0] prev_data;
    bit         prev_stall;
    cap.delete();
    done_cnt   = 0;
    hold_bad   = 0;
    timed_out  = 1'b1;
    prev_stall = 1'b0;
    prev_data  = 4'h0;
    inStartTx  = 1'b1;
    inFrameLen = len;
    tick();
    inStartTx  = 1'b0;
    err_after_start = o_error;
    for (int c = 0; c < 200; c++) begin
      inSymReady = toggle ? (c % 2 == 0) : 1'b1;
      inStartTx  = poke && (c == 3);
      if (o_txDone) done_cnt++;
      if (prev_stall && (o_symData !== prev_data || !o_symValid)) hold_bad++;
      if (o_symValid && inSymReady) cap.push_back(o_symData);
      prev_stall = o_symValid && !inSymReady;
      prev_data  = o_symData;
      if (!o_busy && !o_txDone) begin
        timed_out = 1'b0;
        break;
      end
      tick();
    end
    inSymReady = 1'b0;
    inStartTx  = 1'b0;
  endtask

  task automatic test_reset();
    inReset = 1'b1;
    repeat (5) tick();
    inReset = 1'b0;
    tick();
    checks++;
    if ({o_symValid, o_busy, o_txDone, o_fifoFull, o_error} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs: got valid/busy/done/full/err=%b expected 00000",
               {o_symValid, o_busy, o_txDone, o_fifoFull, o_error});
    end
    checks++;
    if (o_symData !== 4'h0) begin
      errors++;
      $display("FAIL reset_symdata: got %h expected 0", o_symData);
    end
  endtask

  task automatic test_basic_frame();
    int d;
    write_sym(4'hB);
    write_sym(4'hF);
    expect_header(7'd1);
    exp_q.push_back(4'hB);
    exp_q.push_back(4'hF);
    run_frame(7'd1, 1'b0, 1'b1);
    d = stream_diff();
    checks++;
    if (timed_out) begin
      errors++;
      $display("FAIL basic_timeout: frame did not return idle within budget");
    end
    checks++;
    if (d != -1) begin
      errors++;
      $display("FAIL basic_stream: %0d symbols, diff code %0d, expected 14 symbols 0x8,7,A,1,0,B,F", cap.size(), d);
    end
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL basic_txdone: pulse cycles %0d expected 1", done_cnt);
    end
    checks++;
    if (o_busy !== 1'b0 || o_symValid !== 1'b0) begin
      errors++;
      $display("FAIL basic_idle: busy=%b valid=%b expected 0 0", o_busy, o_symValid);
    end
    checks++;
    if (o_error !== 1'b0) begin
      errors++;
      $display("FAIL busy_start_ignored: error=%b expected 0", o_error);
    end
  endtask

  task automatic test_backpressure();
    int d;
    write_sym(4'hB);
    write_sym(4'hF);
    expect_header(7'd1);
    exp_q.push_back(4'hB);
    exp_q.push_back(4'hF);
    run_frame(7'd1, 1'b1, 1'b0);
    d = stream_diff();
    checks++;
    if (timed_out || d != -1) begin
      errors++;
      $display("FAIL bp_stream: %0d symbols, diff code %0d, timeout %0d expected 14 symbols", cap.size(), d, timed_out);
    end
    checks++;
    if (hold_bad != 0) begin
      errors++;
      $display("FAIL bp_hold: %0d unstable stalled cycles expected 0", hold_bad);
    end
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL bp_txdone: pulse cycles %0d expected 1", done_cnt);
    end
  endtask

  task automatic test_underrun();
    write_sym(4'hE);
    write_sym(4'h5);
    run_frame(7'd2, 1'b0, 1'b0);
    checks++;
    if (timed_out || cap.size() != 14) begin
      errors++;
      $display("FAIL underrun_count: %0d transfers timeout %0d expected 14", cap.size(), timed_out);
    end
    checks++;
    if (cap.size() == 14 && (cap[12] !== 4'hE || cap[13] !== 4'h5 || cap[10] !== 4'h2)) begin
      errors++;
      $display("FAIL underrun_tail: phr/payload %h %h %h expected 2 E 5", cap[10], cap[12], cap[13]);
    end
    checks++;
    if (o_error !== 1'b1 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL underrun_flags: error=%b busy=%b expected 1 0", o_error, o_busy);
    end
    checks++;
    if (done_cnt != 0) begin
      errors++;
      $display("FAIL underrun_txdone: pulse cycles %0d expected 0", done_cnt);
    end
  endtask

  task automatic test_overflow();
    int d;
    inReset = 1'b1;
    tick();
    inReset = 1'b0;
    write_sym(4'hB);
    write_sym(4'hF);
    write_sym(4'hE);
    checks++;
    if (o_fifoFull !== 1'b0) begin
      errors++;
      $display("FAIL ovf_not_full_at_3: full=%b expected 0", o_fifoFull);
    end
    write_sym(4'h5);
    checks++;
    if (o_fifoFull !== 1'b1 || o_error !== 1'b0) begin
      errors++;
      $display("FAIL ovf_full_at_4: full=%b error=%b expected 1 0", o_fifoFull, o_error);
    end
    write_sym(4'hA);
    checks++;
    if (o_error !== 1'b1 || o_fifoFull !== 1'b1) begin
      errors++;
      $display("FAIL ovf_drop: error=%b full=%b expected 1 1", o_error, o_fifoFull);
    end
    expect_header(7'd2);
    exp_q.push_back(4'hB);
    exp_q.push_back(4'hF);
    exp_q.push_back(4'hE);
    exp_q.push_back(4'h5);
    run_frame(7'd2, 1'b0, 1'b0);
    checks++;
    if (err_after_start !== 1'b0) begin
      errors++;
      $display("FAIL ovf_start_clears: error=%b expected 0", err_after_start);
    end
    d = stream_diff();
    checks++;
    if (timed_out || d != -1 || done_cnt != 1) begin
      errors++;
      $display("FAIL ovf_stream: %0d symbols diff %0d done %0d expected 16 symbols ending B,F,E,5 and 1 done", cap.size(), d, done_cnt);
    end
  endtask

  task automatic test_bad_len_and_reset();
    int d;
    inStartTx  = 1'b1;
    inFrameLen = 7'd0;
    tick();
    inStartTx  = 1'b0;
    checks++;
    if (o_error !== 1'b1 || o_busy !== 1'b0 || o_symValid !== 1'b0) begin
      errors++;
      $display("FAIL bad_len: error=%b busy=%b valid=%b expected 1 0 0", o_error, o_busy, o_symValid);
    end
    write_sym(4'hC);
    write_sym(4'hD);
    write_sym(4'hE);
    inStartTx  = 1'b1;
    inFrameLen = 7'd2;
    tick();
    inStartTx  = 1'b0;
    inSymReady = 1'b1;
    repeat (13) tick();
    checks++;
    if (o_symValid !== 1'b1 || o_symData !== 4'hD) begin
      errors++;
      $display("FAIL midframe_pos: valid=%b data=%h expected 1 D", o_symValid, o_symData);
    end
    inReset = 1'b1;
    tick();
    inReset = 1'b0;
    inSymReady = 1'b0;
    checks++;
    if ({o_symValid, o_busy, o_txDone, o_fifoFull, o_error} !== 5'b0 || o_symData !== 4'h0) begin
      errors++;
      $display("FAIL midframe_reset: valid/busy/done/full/err=%b data=%h expected 00000 0",
               {o_symValid, o_busy, o_txDone, o_fifoFull, o_error}, o_symData);
    end
    write_sym(4'h1);
    write_sym(4'h2);
    write_sym(4'h3);
    checks++;
    if (o_fifoFull !== 1'b0) begin
      errors++;
      $display("FAIL reset_flush: full=%b after 3 writes expected 0", o_fifoFull);
    end
    write_sym(4'h4);
    expect_header(7'd2);
    exp_q.push_back(4'h1);
    exp_q.push_back(4'h2);
    exp_q.push_back(4'h3);
    exp_q.push_back(4'h4);
    run_frame(7'd2, 1'b0, 1'b0);
    d = stream_diff();
    checks++;
    if (timed_out || d != -1 || done_cnt != 1) begin
      errors++;
      $display("FAIL post_reset_frame: %0d symbols diff %0d done %0d expected 16 symbols ending 1,2,3,4", cap.size(), d, done_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_backpressure();
    test_underrun();
    test_overflow();
    test_bad_len_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
